// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle mover and spawner: each vsync rising edge walks every slot once, then offers one spawn.
// A frame pass takes NUM_OBSTACLES+1 cycles. A spawn request is held by the requester until spawn_ack.
package obstacle_scheduler_pkg;
    typedef struct packed {
        logic        active;
        logic [1:0]  lane;
        logic [10:0] position;
    } obstacle_t;
endpackage

module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int NUM_OBSTACLES = 10
) (
    input  logic                            system_clock_in,
    input  logic                            reset_n_in,
    input  logic                            vsync,
    input  logic                            enable_in,
    input  logic                            clear_in,
    input  logic [3:0]                      speed_in,
    input  logic                            spawn_req,
    input  logic [1:0]                      spawn_lane,
    output logic                            spawn_ack,
    output logic                            spawn_drop,
    output obstacle_t [NUM_OBSTACLES-1:0]   obstacles,
    output logic                            busy
);
    localparam int IDX_W = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBSTACLES - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

    state_t           state, state_nxt;
    logic             vsync_q;
    logic             armed;
    logic             pending;
    logic             tick;
    logic [IDX_W-1:0] idx;
    logic [3:0]       speed_lat;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             spawn_ok;

    // armed stays low until vsync is seen low, so a level held across reset is not a tick
    assign tick = vsync & ~vsync_q & armed;
    assign busy = (state != IDLE);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
            if (!obstacles[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        spawn_ack  = 1'b0;
        spawn_drop = 1'b0;
        spawn_ok   = 1'b0;
        case (state)
            IDLE:   if (enable_in && (tick || pending)) state_nxt = UPDATE;
            UPDATE: if (idx == LAST_IDX) state_nxt = SPAWN;
            SPAWN: begin
                state_nxt = IDLE;
                if (spawn_req && enable_in) begin
                    spawn_ack = 1'b1;
                    if (spawn_lane == 2'd3 || !free_found) spawn_drop = 1'b1;
                    else                                   spawn_ok   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear_in) begin
            state_nxt  = IDLE;
            spawn_ack  = 1'b0;
            spawn_drop = 1'b0;
            spawn_ok   = 1'b0;
        end
    end

    always_ff @(posedge system_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= IDLE;
            vsync_q   <= 1'b0;
            armed     <= 1'b0;
            pending   <= 1'b0;
            idx       <= '0;
            speed_lat <= '0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync;
            armed   <= armed | ~vsync;
            // in IDLE a pending tick is either consumed by UPDATE or discarded while disabled
            if (clear_in || state == IDLE) pending <= 1'b0;
            else if (tick)                 pending <= 1'b1;
            if (state == UPDATE) idx <= idx + 1'b1;
            else                 idx <= '0;
            if (state == IDLE && state_nxt == UPDATE) speed_lat <= speed_in;
        end
    end

    always_ff @(posedge system_clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            obstacles <= '0;
        end else if (clear_in) begin
            obstacles <= '0;
        end else if (state == UPDATE) begin
            if (obstacles[idx].active) begin
                if (obstacles[idx].position >= {7'd0, speed_lat}) begin
                    obstacles[idx].position <= obstacles[idx].position - {7'd0, speed_lat};
                end else begin
                    obstacles[idx].active   <= 1'b0;
                    obstacles[idx].position <= '0;
                end
            end
        end else if (spawn_ok) begin
            obstacles[free_idx] <= '{active: 1'b1, lane: spawn_lane, position: 11'(SCREEN_WIDTH)};
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: vector table of frames plus hand sequences, spawn acks scored from a queue.
module tb_obstacle_scheduler;
    import obstacle_scheduler_pkg::*;

    localparam int NUM = 10;
    localparam int SW  = 1024;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                vsync;
    logic                enable_in;
    logic                clear_in;
    logic [3:0]          speed_in;
    logic                spawn_req;
    logic [1:0]          spawn_lane;
    logic                spawn_ack;
    logic                spawn_drop;
    obstacle_t [NUM-1:0] obstacles;
    logic                busy;

    obstacle_scheduler #(.SCREEN_WIDTH(SW), .NUM_OBSTACLES(NUM)) dut (
        .system_clock_in (clk),
        .reset_n_in      (reset_n),
        .vsync           (vsync),
        .enable_in       (enable_in),
        .clear_in        (clear_in),
        .speed_in        (speed_in),
        .spawn_req       (spawn_req),
        .spawn_lane      (spawn_lane),
        .spawn_ack       (spawn_ack),
        .spawn_drop      (spawn_drop),
        .obstacles       (obstacles),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int                  checks = 0;
    int                  errors = 0;
    logic                sb[$];
    obstacle_t [NUM-1:0] model;

    typedef struct {
        logic [3:0] speed;
        logic       req;
        logic [1:0] lane;
        logic       exp_drop;
        int         exp_count;
        int         exp_pos0;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int count_active(input obstacle_t [NUM-1:0] o);
        int n = 0;
        for (int i = 0; i < NUM; i++) if (o[i].active) n++;
        return n;
    endfunction

    task automatic model_update(input logic [3:0] spd);
        for (int i = 0; i < NUM; i++) begin
            if (model[i].active) begin
                if (model[i].position >= 11'(spd)) model[i].position = model[i].position - 11'(spd);
                else begin
                    model[i].active   = 1'b0;
                    model[i].position = '0;
                end
            end
        end
    endtask

    task automatic model_spawn(input logic [1:0] lane);
        bit placed = 0;
        for (int i = 0; i < NUM; i++) begin
            if (!placed && !model[i].active) begin
                model[i] = '{active: 1'b1, lane: lane, position: 11'(SW)};
                placed = 1;
            end
        end
    endtask

    // every ack cycle consumes one expected drop value; an empty queue means an unrequested ack
    always @(negedge clk) begin
        if (spawn_ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected actual=1 expected=0 drop=%0b", spawn_drop);
            end else begin
                logic exp_drop;
                exp_drop = sb.pop_front();
                if (spawn_drop !== exp_drop) begin
                    errors++;
                    $display("FAIL ack_drop actual=%0b expected=%0b", spawn_drop, exp_drop);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [3:0] spd, input logic req, input logic [1:0] lane,
                             input logic exp_drop);
        bit started = 0;
        bit done = 0;
        speed_in   = spd;
        spawn_req  = req;
        spawn_lane = lane;
        if (req) sb.push_back(exp_drop);
        vsync = 1'b1;
        for (int i = 0; i < 5 && !started; i++) begin
            cycle();
            if (busy) started = 1;
        end
        check("frame_start", started, 1);
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            if (!busy) done = 1;
        end
        check("frame_done", done, 1);
        spawn_req = 1'b0;
        vsync     = 1'b0;
        cycle();
        model_update(spd);
        if (req && !exp_drop) model_spawn(lane);
        if (req) check("ack_seen", sb.size(), 0);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        cycle();
        clear_in = 1'b0;
        model = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int passes;
        bit prev_busy;
        bit seen;
        bit started;

        vecs[0] = '{speed: 4'd4,  req: 1'b1, lane: 2'd2, exp_drop: 1'b0, exp_count: 2, exp_pos0: 1020};
        vecs[1] = '{speed: 4'd0,  req: 1'b0, lane: 2'd0, exp_drop: 1'b0, exp_count: 2, exp_pos0: 1020};
        vecs[2] = '{speed: 4'd15, req: 1'b1, lane: 2'd3, exp_drop: 1'b1, exp_count: 2, exp_pos0: 1005};
        vecs[3] = '{speed: 4'd5,  req: 1'b1, lane: 2'd0, exp_drop: 1'b0, exp_count: 3, exp_pos0: 1000};
        vecs[4] = '{speed: 4'd15, req: 1'b1, lane: 2'd1, exp_drop: 1'b0, exp_count: 4, exp_pos0: 985};

        reset_n = 1'b0; vsync = 1'b0; enable_in = 1'b0; clear_in = 1'b0;
        speed_in = '0; spawn_req = 1'b0; spawn_lane = '0;
        model = '0;
        repeat (3) cycle();
        check("reset_slots", obstacles, 0);
        check("reset_busy", busy, 0);
        check("reset_ack", {spawn_ack, spawn_drop}, 0);
        reset_n = 1'b1;
        enable_in = 1'b1;
        repeat (2) cycle();

        // first spawn lands in slot 0 at the screen edge
        run_frame(4'd0, 1'b1, 2'd1, 1'b0);
        check("first_spawn", obstacles[0], {1'b1, 2'd1, 11'd1024});

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].speed, vecs[v].req, vecs[v].lane, vecs[v].exp_drop);
            check($sformatf("vec%0d_count", v), count_active(obstacles), vecs[v].exp_count);
            check($sformatf("vec%0d_pos0", v), obstacles[0].position, vecs[v].exp_pos0);
            check($sformatf("vec%0d_slots", v), obstacles, model);
        end

        // slot 0 travels 1024 px at 8 px/frame, reaching 0 still active, then retires
        do_clear();
        check("clear_slots", obstacles, 0);
        run_frame(4'd0, 1'b1, 2'd2, 1'b0);
        for (int f = 0; f < 128; f++) run_frame(4'd8, 1'b0, 2'd0, 1'b0);
        check("travel_pos0", obstacles[0].position, 0);
        check("travel_active", obstacles[0].active, 1);
        run_frame(4'd8, 1'b0, 2'd0, 1'b0);
        check("retire_active", obstacles[0].active, 0);
        check("retire_slots", obstacles, model);

        // full table drops the request
        do_clear();
        for (int i = 0; i < NUM; i++) run_frame(4'd0, 1'b1, 2'(i % 3), 1'b0);
        check("full_count", count_active(obstacles), NUM);
        run_frame(4'd0, 1'b1, 2'd0, 1'b1);
        check("full_unchanged", obstacles, model);

        // second vsync edge lands mid-UPDATE and is held as one pending pass
        speed_in = 4'd3;
        passes = 0;
        prev_busy = busy;
        for (int i = 0; i < 50; i++) begin
            if (i == 0 || i == 3) vsync = 1'b1;
            if (i == 1 || i == 4) vsync = 1'b0;
            cycle();
            if (busy && !prev_busy) passes++;
            prev_busy = busy;
        end
        model_update(4'd3);
        model_update(4'd3);
        check("pending_passes", passes, 2);
        check("pending_slots", obstacles, model);
        check("pending_pos0", obstacles[0].position, 1018);

        // clear mid-UPDATE wipes everything on the next cycle
        do_clear();
        for (int i = 0; i < 5; i++) run_frame(4'd0, 1'b1, 2'd1, 1'b0);
        check("five_count", count_active(obstacles), 5);
        speed_in = 4'd2;
        vsync = 1'b1;
        started = 0;
        for (int i = 0; i < 5 && !started; i++) begin
            cycle();
            if (busy) started = 1;
        end
        check("clear_frame_start", started, 1);
        repeat (3) cycle();
        do_clear();
        check("midclear_slots", obstacles, 0);
        check("midclear_busy", busy, 0);
        vsync = 1'b0;
        repeat (20) cycle();
        check("midclear_stays_idle", {busy, obstacles}, 0);

        // disabled game ignores frame ticks
        run_frame(4'd0, 1'b1, 2'd0, 1'b0);
        enable_in = 1'b0;
        vsync = 1'b1;
        seen = 0;
        repeat (8) begin
            cycle();
            if (busy) seen = 1;
        end
        check("disabled_no_pass", seen, 0);
        vsync = 1'b0;
        cycle();
        enable_in = 1'b1;
        repeat (20) cycle();
        check("disabled_slots", obstacles, model);

        // asynchronous reset mid-UPDATE, then a held-high vsync must not tick
        speed_in = 4'd1;
        vsync = 1'b1;
        started = 0;
        for (int i = 0; i < 5 && !started; i++) begin
            cycle();
            if (busy) started = 1;
        end
        check("reset_frame_start", started, 1);
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_slots", obstacles, 0);
        check("async_reset_busy", {busy, spawn_ack, spawn_drop}, 0);
        model = '0;
        repeat (2) cycle();
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            cycle();
            if (busy) seen = 1;
        end
        check("no_stale_tick", seen, 0);
        vsync = 1'b0;
        cycle();
        run_frame(4'd2, 1'b1, 2'd2, 1'b0);
        check("post_reset_slots", obstacles, model);

        repeat (3) cycle();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The block SHALL have parameter SCREEN_WIDTH, default 1024, giving the spawn x-position for new obstacles.
REQ-002 The block SHALL have parameter NUM_OBSTACLES, default 10, giving the number of obstacle slots.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port system_clock_in, input, 1, SHALL be the system clock.
REQ-005 Port reset_n_in, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port vsync, input, 1, SHALL be the raw video vsync; its rising edge marks one frame tick.
REQ-007 Port enable_in, input, 1, SHALL be the game-running flag; low freezes motion and blocks spawning.
REQ-008 Port clear_in, input, 1, SHALL be a one-cycle pulse that deactivates all slots.
REQ-009 Port speed_in, input, 4, SHALL be the pixels moved per frame; it is sampled at each frame tick.
REQ-010 Port spawn_req, input, 1, SHALL be a spawn request, held until acknowledged.
REQ-011 Port spawn_lane, input, 2, SHALL be the lane for the request; valid values are 0 to 2.
REQ-012 Port spawn_ack, output, 1, SHALL be a one-cycle acknowledge for a spawn request.
REQ-013 Port spawn_drop, output, 1, SHALL pulse together with spawn_ack when the request was discarded.
REQ-014 Port obstacles, output, obstacle[NUM_OBSTACLES-1:0], SHALL be the slot array; each entry has active, lane[1:0] and position[10:0].
REQ-015 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 Frame-tick detection:
- vsync SHALL be registered once.
- A tick SHALL be the registered value 0->1.
- Tick latency to leaving IDLE SHALL be 1 cycle.
REQ-017 FSM states SHALL be IDLE, UPDATE and SPAWN; reset state is IDLE.
REQ-018 IDLE SHALL go to UPDATE on a tick, or on a pending tick, when enable_in=1; when enable_in=0 ticks SHALL be discarded.
REQ-019 UPDATE SHALL process one slot per cycle, index 0 to NUM_OBSTACLES-1, then go to SPAWN.
REQ-020 Slot update:
- An active slot with position >= speed SHALL get position -= speed.
- An active slot with position < speed SHALL become inactive, with position 0.
- Inactive slots SHALL be unchanged.
REQ-021 SPAWN SHALL last 1 cycle, then go to IDLE.
- If spawn_req=1 in SPAWN, spawn_ack SHALL pulse that cycle.
- If a free slot exists, the lowest-index free slot SHALL become active with lane=spawn_lane and position=SCREEN_WIDTH, visible the next cycle.
- If no slot is free, spawn_drop SHALL pulse with spawn_ack.
REQ-022 At most one spawn SHALL be accepted per frame; spawn_req outside SPAWN SHALL be ignored.
REQ-023 spawn_lane=3 SHALL be acknowledged with spawn_drop=1, and no slot SHALL change.
REQ-024 A tick arriving while busy SHALL set a single pending flag; further ticks while pending SHALL be lost.
- The pending flag SHALL clear when UPDATE starts.
REQ-025 speed_in SHALL be latched at UPDATE entry; speed 0 SHALL leave positions unchanged.
REQ-026 clear_in SHALL have priority over all other activity:
- Next cycle: every slot is inactive, position 0, lane 0.
- FSM returns to IDLE and the pending flag clears.
- No ack is generated that cycle.
REQ-027 enable_in falling mid-UPDATE SHALL let the current frame pass complete.
REQ-028 The obstacles output SHALL be registered, and each slot SHALL change at most once per frame pass.

Reset
REQ-029 On reset_n_in=0, regardless of clock:
- All slots: active=0, lane=0, position=0.
- FSM = IDLE; pending flag, vsync register, spawn_ack, spawn_drop and busy = 0.
REQ-030 After reset_n_in deasserts, the first tick SHALL require a fresh vsync 0->1 edge.

Verification
REQ-031 Reset, enable=1, spawn_req=1, lane=1, one tick -> slot0 {1,1,1024}, spawn_ack=1 for one cycle, spawn_drop=0.
REQ-032 Slot0 at 1024, speed=8, 128 ticks -> position 0 and still active; next tick -> slot0 inactive.
REQ-033 All 10 slots active, spawn_req=1 at a tick -> spawn_ack=1 and spawn_drop=1, no slot changes.
REQ-034 Two vsync edges 3 cycles apart, the second during UPDATE -> exactly two UPDATE passes, positions reduced by 2*speed.
REQ-035 clear_in pulse mid-UPDATE with 5 active slots -> next cycle all inactive, busy=0.
REQ-036 reset_n_in asserted asynchronously mid-UPDATE -> outputs zero before the next clock edge.
